// File: rtl/iterative_restoring_divider_64_32_pkg.sv
// Shared constants and FSM state encoding for the iterative restoring divider.
package iterative_restoring_divider_64_32_pkg;

    localparam int N_DEFAULT    = 32;
    localparam int ITER_DEFAULT = 2 * N_DEFAULT;
    localparam int CNT_W        = $clog2(ITER_DEFAULT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_RUN    = 3'b010,
        S_FINISH = 3'b100
    } state_t;

endpackage

// File: rtl/iterative_divider_control.sv
// Divider control: IDLE/RUN/FINISH FSM, iteration counter and datapath strobes.
module iterative_divider_control
    import iterative_restoring_divider_64_32_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT,
    parameter int CW   = $clog2(ITER)
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic start,
    input  logic b_zero,
    output logic busy,
    output logic done,
    output logic load,
    output logic load_zero,
    output logic shift,
    output logic last
);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          cnt_last;

    assign cnt_last = (cnt == CW'(ITER - 1));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Counter saturates at ITER-1; it only returns to zero on a reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (shift && !cnt_last) begin
            cnt <= cnt + CW'(1);
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        load_zero  = 1'b0;
        shift      = 1'b0;
        last       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && enable) begin
                    if (b_zero) begin
                        load_zero  = 1'b1;
                        state_next = S_FINISH;
                    end else begin
                        load       = 1'b1;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                shift = enable;
                if (cnt_last) begin
                    last       = enable;
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/subtract_Nbit.sv
// Generic W-bit subtractor: diff = a - b; cout_sub is high when no borrow occurs.
module subtract_Nbit #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         cout_sub
);

    // Two's-complement subtract; the carry out of a + ~b + 1 is the inverted borrow.
    assign {cout_sub, diff} = {1'b0, a} + {1'b0, ~b} + (W + 1)'(1);

endmodule

// File: rtl/iterative_restoring_divider_64_32.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module iterative_restoring_divider_64_32
    import iterative_restoring_divider_64_32_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           start,
    input  logic [2*N-1:0] A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] Q,
    output logic [N-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero
);

    localparam int ITER = 2 * N;

    logic           load;
    logic           load_zero;
    logic           shift;
    logic           last;

    logic [2*N-1:0] s;
    logic [N-1:0]   d;
    logic [N:0]     p;

    logic [N:0]     p_shift;
    logic [N:0]     diff;
    logic           no_borrow;
    logic [N:0]     p_next;
    logic [2*N-1:0] s_next;

    iterative_divider_control #(
        .ITER (ITER)
    ) u_control (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .b_zero    (B == '0),
        .busy      (busy),
        .done      (done),
        .load      (load),
        .load_zero (load_zero),
        .shift     (shift),
        .last      (last)
    );

    // P stays below D after every step, so its top bit is always zero before the shift.
    assign p_shift = (p << 1) | {{N{1'b0}}, s[2*N-1]};

    subtract_Nbit #(
        .W (N + 1)
    ) u_sub (
        .a        (p_shift),
        .b        ({1'b0, d}),
        .diff     (diff),
        .cout_sub (no_borrow)
    );

    assign p_next = no_borrow ? diff : p_shift;
    assign s_next = {s[2*N-2:0], no_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
            d <= '0;
            p <= '0;
        end else if (load) begin
            s <= A;
            d <= B;
            p <= '0;
        end else if (shift) begin
            s <= s_next;
            p <= p_next;
        end
    end

    // Results only change on an accepted start or the final iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else if (load) begin
            div_by_zero <= 1'b0;
        end else if (load_zero) begin
            Q           <= '1;
            R           <= A[N-1:0];
            div_by_zero <= 1'b1;
        end else if (last) begin
            Q <= s_next;
            R <= p_next[N-1:0];
        end
    end

endmodule
